// File: rtl/tanh_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tanh_host_driver
// Description : Initiator side of the tanh core Start/ready handshake.
//               Queues operands from an upstream valid/ready stream, issues
//               one core job per operand, and presents each result (or a
//               timeout error) on a downstream valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tanh_host_driver #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             core_start,
    input  logic             core_ready,
    output logic [WIDTH-1:0] core_x,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_tmr_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_tmr_w-1:0] c_timeout = c_tmr_w'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RELEASE = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_ERR     = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    // Operand FIFO storage and bookkeeping
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    // Sequencer state and registered outputs
    state_t              r_state;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_core_start;
    logic [WIDTH-1:0]    r_core_x;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_err;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // in_ready comes straight from the count register, so a pop while full
    // only reopens the input on the following cycle.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && core_ready;

    assign in_ready   = !w_full;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign core_start = r_core_start;
    assign core_x     = r_core_x;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;

    // FIFO data array: written on every accepted push, contents need no reset
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Job sequencer: one core job at a time, result held until accepted
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_core_start <= 1'b0;
            r_core_x     <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_core_x     <= r_mem[r_rd_ptr];
                        r_core_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_core_start <= 1'b0;
                    r_timer      <= '0;
                    r_state      <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Core acknowledges the job by leaving its idle state
                    if (!core_ready) begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end else if (r_timer == c_timeout) begin
                        r_state <= S_ERR;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                S_WAIT: begin
                    // Core signals completion by returning to idle
                    if (core_ready) begin
                        r_state <= S_CAPTURE;
                    end else if (r_timer == c_timeout) begin
                        r_state <= S_ERR;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                S_CAPTURE: begin
                    r_out_data  <= core_result;
                    r_out_err   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_ERR: begin
                    r_out_data  <= '0;
                    r_out_err   <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
